// File: rtl/axis_chk_pkg.sv
// Shared types, default parameters and the expected-byte helper for the
// AXI4-Stream fixed-pattern packet checker.
package axis_chk_pkg;

    localparam int          DEF_DATA_W        = 512;
    localparam int          DEF_BEATS_PER_PKT = 8;
    localparam logic [7:0]  DEF_STEP          = 8'h0F;
    localparam int          DEF_CNT_W         = 16;

    typedef enum logic [1:0] {
        RECV    = 2'd0,
        OVERRUN = 2'd1,
        REPORT  = 2'd2
    } axis_chk_state_t;

    // Only the low 8 bits of the index matter, since the product is taken mod 256.
    function automatic logic [7:0] exp_byte0(input logic [7:0] idx, input logic [7:0] step);
        return idx * step;
    endfunction

endpackage

// File: rtl/axis_beat_compare.sv
// Combinational check of one captured beat: byte 0 must follow the
// idx*STEP ramp and every higher byte must be zero.
module axis_beat_compare
    import axis_chk_pkg::*;
#(
    parameter int         DATA_W = DEF_DATA_W,
    parameter int         IDX_W  = 3,
    parameter logic [7:0] STEP   = DEF_STEP
) (
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  beat_idx,
    output logic              data_ok
);

    logic [7:0] exp_b0;

    assign exp_b0 = exp_byte0(8'(beat_idx), STEP);

    generate
        if (DATA_W > 8) begin : g_wide
            assign data_ok = (data[7:0] == exp_b0) && (data[DATA_W-1:8] == '0);
        end else begin : g_narrow
            assign data_ok = (data[7:0] == exp_b0);
        end
    endgenerate

endmodule

// File: rtl/axis_pattern_checker.sv
// AXI4-Stream sink that checks fixed-pattern packets beat by beat and
// reports per-packet results, sticky error flags and saturating counts.
//
// state   | meaning
// RECV    | accepting and data-checking beats of the current packet
// OVERRUN | expected length reached without tlast; discard beats until tlast
// REPORT  | one-cycle bubble: publish result, update counters, clear accumulator
module axis_pattern_checker
    import axis_chk_pkg::*;
#(
    parameter int         DATA_W        = DEF_DATA_W,
    parameter int         BEATS_PER_PKT = DEF_BEATS_PER_PKT,
    parameter logic [7:0] STEP          = DEF_STEP,
    parameter int         CNT_W         = DEF_CNT_W
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              pkt_done,
    output logic              pkt_ok,
    output logic              err_data,
    output logic              err_early_last,
    output logic              err_missing_last,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  bad_pkt_count
);

    localparam int               IDX_W    = $clog2(BEATS_PER_PKT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_PKT - 1);

    axis_chk_state_t    state, state_next;
    logic [IDX_W-1:0]   beat_idx;
    logic [DATA_W-1:0]  cap_data;
    logic [IDX_W-1:0]   cap_idx;
    logic               cap_chk;
    logic               acc_err;
    logic               err_data_r;
    logic               data_ok;

    logic               accept;
    logic               at_last_idx;
    logic               recv_accept;
    logic               early_last;
    logic               missing_last;
    logic               cur_err;

    assign accept       = s_axis_tvalid & s_axis_tready;
    assign at_last_idx  = (beat_idx == LAST_IDX);
    assign recv_accept  = accept & (state == RECV);
    assign early_last   = recv_accept &  s_axis_tlast & ~at_last_idx;
    assign missing_last = recv_accept & ~s_axis_tlast &  at_last_idx;
    assign cur_err      = cap_chk & ~data_ok;

    axis_beat_compare #(
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .STEP     (STEP)
    ) u_cmp (
        .data     (cap_data),
        .beat_idx (cap_idx),
        .data_ok  (data_ok)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= RECV;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RECV: begin
                if (accept && (s_axis_tlast || at_last_idx)) begin
                    state_next = s_axis_tlast ? REPORT : OVERRUN;
                end
            end
            OVERRUN: begin
                if (accept && s_axis_tlast) begin
                    state_next = REPORT;
                end
            end
            REPORT:  state_next = RECV;
            default: state_next = RECV;
        endcase
    end

    // tready is gated by reset so a beat offered during reset is never handshaken.
    always_comb begin
        s_axis_tready = 1'b0;
        pkt_done      = 1'b0;
        pkt_ok        = 1'b0;
        if (!areset && state != REPORT) begin
            s_axis_tready = 1'b1;
        end
        if (state == REPORT) begin
            pkt_done = 1'b1;
            pkt_ok   = ~(acc_err | cur_err);
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            cap_data <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_idx <= '0;
            cap_idx  <= '0;
            cap_chk  <= 1'b0;
        end else begin
            cap_chk <= recv_accept;
            if (recv_accept) begin
                cap_idx  <= beat_idx;
                beat_idx <= (s_axis_tlast || at_last_idx) ? '0 : beat_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_err <= 1'b0;
        end else if (state == REPORT) begin
            acc_err <= 1'b0;
        end else begin
            acc_err <= acc_err | cur_err | early_last | missing_last;
        end
    end

    // err_data includes the beat under compare so it rises the cycle after acceptance.
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_data_r       <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            err_data_r       <= err_data_r | cur_err;
            err_early_last   <= err_early_last | early_last;
            err_missing_last <= err_missing_last | missing_last;
        end
    end

    assign err_data = err_data_r | cur_err;

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_count     <= '0;
            bad_pkt_count <= '0;
        end else if (state == REPORT) begin
            if (pkt_count != '1) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (!pkt_ok && bad_pkt_count != '1) begin
                bad_pkt_count <= bad_pkt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Bench for axis_pattern_checker: directed packets from the test plan plus a
// randomized packet stream, compared every cycle against a beat-level model.
module tb_axis_pattern_checker;

    localparam int DATA_W  = 512;
    localparam int BEATS   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic              clk;
    logic              areset;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              pkt_done;
    logic              pkt_ok;
    logic              err_data;
    logic              err_early_last;
    logic              err_missing_last;
    logic [CNT_W-1:0]  pkt_count;
    logic [CNT_W-1:0]  bad_pkt_count;

    int checks   = 0;
    int failures = 0;
    int obs_done = 0;
    int obs_ok   = 0;
    bit chk_en   = 0;

    // behavioural model state
    int m_n      = 0;
    bit m_over   = 0;
    bit m_err    = 0;
    bit m_report = 0;
    bit m_edata  = 0;
    bit m_eearly = 0;
    bit m_emiss  = 0;
    int m_cnt    = 0;
    int m_bad    = 0;

    axis_pattern_checker #(
        .DATA_W        (DATA_W),
        .BEATS_PER_PKT (BEATS),
        .STEP          (8'h0F),
        .CNT_W         (CNT_W)
    ) dut (
        .aclk             (clk),
        .areset           (areset),
        .s_axis_tdata     (tdata),
        .s_axis_tvalid    (tvalid),
        .s_axis_tready    (tready),
        .s_axis_tlast     (tlast),
        .pkt_done         (pkt_done),
        .pkt_ok           (pkt_ok),
        .err_data         (err_data),
        .err_early_last   (err_early_last),
        .err_missing_last (err_missing_last),
        .pkt_count        (pkt_count),
        .bad_pkt_count    (bad_pkt_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit beat_good(input logic [DATA_W-1:0] d, input int n);
        logic [DATA_W-1:0] upper;
        upper = d >> 8;
        return (d[7:0] == 8'((n * 15) % 256)) && (upper == '0);
    endfunction

    // Model: packet-level bookkeeping of accepted beats.
    always @(posedge clk) begin
        if (areset) begin
            m_n = 0; m_over = 0; m_err = 0; m_report = 0;
            m_edata = 0; m_eearly = 0; m_emiss = 0; m_cnt = 0; m_bad = 0;
        end else if (m_report) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_err && m_bad < CNT_MAX) m_bad++;
            m_report = 0; m_err = 0; m_over = 0; m_n = 0;
        end else if (tvalid) begin
            if (m_over) begin
                if (tlast) m_report = 1;
            end else begin
                if (!beat_good(tdata, m_n)) begin
                    m_err = 1; m_edata = 1;
                end
                if (tlast) begin
                    if (m_n < BEATS - 1) begin
                        m_err = 1; m_eearly = 1;
                    end
                    m_report = 1; m_n = 0;
                end else if (m_n == BEATS - 1) begin
                    m_err = 1; m_emiss = 1; m_over = 1; m_n = 0;
                end else begin
                    m_n++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tready",        32'(tready),           32'(!areset && !m_report));
            check("pkt_done",      32'(pkt_done),         32'(m_report));
            check("pkt_ok",        32'(pkt_ok),           32'(m_report && !m_err));
            check("err_data",      32'(err_data),         32'(m_edata));
            check("err_early",     32'(err_early_last),   32'(m_eearly));
            check("err_missing",   32'(err_missing_last), 32'(m_emiss));
            check("pkt_count",     32'(pkt_count),        32'(m_cnt));
            check("bad_pkt_count", 32'(bad_pkt_count),    32'(m_bad));
            if (pkt_done) obs_done++;
            if (pkt_done && pkt_ok) obs_ok++;
        end
    end

    task automatic do_reset();
        areset = 1;
        tvalid = 0;
        tlast  = 0;
        repeat (2) @(posedge clk);
        #1;
        areset   = 0;
        obs_done = 0;
        obs_ok   = 0;
    endtask

    // bad_hi = 0 corrupts byte0 with bad_b0; otherwise byte bad_hi is made nonzero.
    task automatic send_pkt(input int nbeats, input int last_at, input int bad_beat,
                            input logic [7:0] bad_b0, input int bad_hi, input int max_gap);
        logic [DATA_W-1:0] d;
        bit rdy;
        int tries;
        for (int i = 0; i < nbeats; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (g > 0) begin
                tvalid = 0;
                tlast  = 0;
                repeat (g) @(posedge clk);
                #1;
            end
            d = '0;
            d[7:0] = 8'((i * 15) % 256);
            if (i == bad_beat) begin
                if (bad_hi == 0) d[7:0] = bad_b0;
                else d[bad_hi*8 +: 8] = 8'($urandom_range(255, 1));
            end
            tdata  = d;
            tvalid = 1;
            tlast  = (i == last_at);
            tries  = 0;
            rdy    = 0;
            while (!rdy && tries < 10) begin
                @(negedge clk);
                rdy = tready;
                @(posedge clk);
                #1;
                tries++;
            end
            if (!rdy) begin
                failures++;
                $display("FAIL handshake_timeout beat=%0d", i);
            end
        end
        tvalid = 0;
        tlast  = 0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1;
        tvalid = 0;
        tlast  = 0;
        tdata  = '0;
        @(posedge clk);
        #1;
        chk_en = 1;
        do_reset();
        @(posedge clk); #2;
        check("rst_tready",    32'(tready), 32'd1);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_flags",     32'({err_data, err_early_last, err_missing_last, pkt_done}), 32'd0);

        // good packet
        send_pkt(8, 7, -1, 8'h00, 0, 0);
        settle();
        check("good_done",  32'(obs_done), 32'd1);
        check("good_ok",    32'(obs_ok), 32'd1);
        check("good_count", 32'(pkt_count), 32'd1);
        check("good_bad",   32'(bad_pkt_count), 32'd0);
        check("good_flags", 32'({err_data, err_early_last, err_missing_last}), 32'd0);

        // data error then good
        do_reset();
        send_pkt(8, 7, 3, 8'h2C, 0, 0);
        send_pkt(8, 7, -1, 8'h00, 0, 0);
        settle();
        check("derr_done",  32'(obs_done), 32'd2);
        check("derr_ok",    32'(obs_ok), 32'd1);
        check("derr_flag",  32'(err_data), 32'd1);
        check("derr_count", 32'(pkt_count), 32'd2);
        check("derr_bad",   32'(bad_pkt_count), 32'd1);

        // early last then good
        do_reset();
        send_pkt(5, 4, -1, 8'h00, 0, 0);
        send_pkt(8, 7, -1, 8'h00, 0, 0);
        settle();
        check("early_done",  32'(obs_done), 32'd2);
        check("early_ok",    32'(obs_ok), 32'd1);
        check("early_flag",  32'(err_early_last), 32'd1);
        check("early_bad",   32'(bad_pkt_count), 32'd1);

        // missing last
        do_reset();
        send_pkt(10, 9, -1, 8'h00, 0, 0);
        settle();
        check("miss_done",  32'(obs_done), 32'd1);
        check("miss_ok",    32'(obs_ok), 32'd0);
        check("miss_flag",  32'(err_missing_last), 32'd1);
        check("miss_data",  32'(err_data), 32'd0);

        // idle gaps
        do_reset();
        send_pkt(8, 7, -1, 8'h00, 0, 3);
        settle();
        check("gap_done", 32'(obs_done), 32'd1);
        check("gap_ok",   32'(obs_ok), 32'd1);

        // reset mid-packet
        do_reset();
        send_pkt(5, -1, -1, 8'h00, 0, 0);
        settle();
        check("abort_nodone", 32'(obs_done), 32'd0);
        do_reset();
        #1;
        check("abort_count", 32'(pkt_count), 32'd0);
        check("abort_flags", 32'({err_data, err_early_last, err_missing_last}), 32'd0);
        send_pkt(8, 7, -1, 8'h00, 0, 0);
        settle();
        check("abort_next_count", 32'(pkt_count), 32'd1);
        check("abort_next_ok",    32'(obs_ok), 32'd1);

        // randomized stream, long enough to saturate the 4-bit counters
        do_reset();
        for (int p = 0; p < 30; p++) begin
            int kind, nb, la, bb, hi;
            logic [7:0] b0;
            kind = $urandom_range(9, 0);
            if (kind < 6) begin
                nb = BEATS; la = BEATS - 1;
            end else if (kind < 8) begin
                nb = $urandom_range(BEATS - 1, 1); la = nb - 1;
            end else begin
                nb = $urandom_range(12, BEATS + 1); la = nb - 1;
            end
            bb = -1; b0 = 8'h00; hi = 0;
            if ($urandom_range(3, 0) == 0) begin
                bb = $urandom_range(nb - 1, 0);
                b0 = 8'((bb * 15) % 256) ^ 8'($urandom_range(255, 1));
                if ($urandom_range(1, 0) == 1) hi = $urandom_range(DATA_W / 8 - 1, 1);
            end
            send_pkt(nb, la, bb, b0, hi, $urandom_range(1, 0) ? 3 : 0);
        end
        settle();
        check("rand_sat_count", 32'(pkt_count), 32'(CNT_MAX));
        check("rand_done",      32'(obs_done), 32'd30);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
